// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, FSM states and
// response status bit positions.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;
  localparam logic [2:0] OP_NOT = 3'd7;

  localparam int unsigned STAT_FLAG = 0;
  localparam int unsigned STAT_DIV0 = 1;

  typedef enum logic [2:0] {
    S_OP, S_A, S_B, S_ISSUE, S_WAIT, S_RSP0, S_RSP1
  } seq_state_e;

  function automatic logic is_div0(input logic [2:0] sel, input logic [7:0] b);
    return (sel == OP_DIV) && (b == 8'h00);
  endfunction

endpackage

// File: rtl/alu_seq_timer.sv
// Inter-byte idle counter: counts cycles while enabled, restarts on clear, and
// flags expiry on the cycle the count would reach FRAME_TIMEOUT (0 disables).
module alu_seq_timer #(
  parameter int unsigned FRAME_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  if (FRAME_TIMEOUT == 0) begin : g_off
    logic w_unused_in;
    assign w_unused_in = ^{clk, rst, i_clr, i_en};
    assign o_expire    = 1'b0;
  end else begin : g_on
    localparam int unsigned CW = (FRAME_TIMEOUT > 1) ? $clog2(FRAME_TIMEOUT) : 1;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
      if (rst || i_clr || !i_en) r_cnt <= '0;
      else                       r_cnt <= r_cnt + CW'(1);
    end

    assign o_expire = i_en && !i_clr && (r_cnt == CW'(FRAME_TIMEOUT - 1));
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Turns 3-byte command frames (opcode, A, B) into one ALU operation and returns
// a 2-byte response (result, status). Optional macro: ALU_DIV0_GUARD_EN.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned ALU_LATENCY   = 1,
  parameter int unsigned FRAME_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_cmd_data,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  output logic [7:0] o_rsp_data,
  output logic       o_rsp_valid,
  input  logic       i_rsp_ready,
  output logic [7:0] o_alu_a,
  output logic [7:0] o_alu_b,
  output logic [2:0] o_alu_sel,
  output logic       o_alu_load,
  input  logic [7:0] i_alu_out,
  input  logic       i_alu_flag,
  output logic       o_busy,
  output logic       o_frame_err
);

`ifdef ALU_DIV0_GUARD_EN
  localparam bit Div0Guard = 1'b1;
`else
  localparam bit Div0Guard = 1'b0;
`endif

  localparam int unsigned WW = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;

  seq_state_e r_state;
  logic [7:0] r_alu_a, r_alu_b, r_res;
  logic [2:0] r_alu_sel;
  logic       r_alu_load, r_flg, r_div0, r_frame_err;
  logic [WW-1:0] r_wait;

  logic       w_cmd_fire, w_expire, w_idle_en;
  logic [7:0] w_status;

  assign w_cmd_fire = i_cmd_valid && o_cmd_ready;
  assign w_idle_en  = (r_state == S_A) || (r_state == S_B);

  alu_seq_timer #(
    .FRAME_TIMEOUT(FRAME_TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_cmd_fire),
    .i_en    (w_idle_en),
    .o_expire(w_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_OP;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_sel   <= '0;
      r_alu_load  <= 1'b0;
      r_res       <= '0;
      r_flg       <= 1'b0;
      r_div0      <= 1'b0;
      r_frame_err <= 1'b0;
      r_wait      <= '0;
    end else begin
      r_alu_load  <= 1'b0;
      r_frame_err <= 1'b0;
      unique case (r_state)
        S_OP: if (w_cmd_fire) begin
          r_alu_sel <= i_cmd_data[2:0];
          r_state   <= S_A;
        end
        S_A: if (w_cmd_fire) begin
          r_alu_a <= i_cmd_data;
          r_state <= S_B;
        end else if (w_expire) begin
          r_frame_err <= 1'b1;
          r_state     <= S_OP;
        end
        S_B: if (w_cmd_fire) begin
          r_alu_b <= i_cmd_data;
          // Load is registered, so the guard decision is made as B arrives.
          r_alu_load <= !(Div0Guard && is_div0(r_alu_sel, i_cmd_data));
          r_state    <= S_ISSUE;
        end else if (w_expire) begin
          r_frame_err <= 1'b1;
          r_state     <= S_OP;
        end
        S_ISSUE: begin
          r_wait <= '0;
          if (Div0Guard && is_div0(r_alu_sel, r_alu_b)) begin
            r_res   <= 8'h00;
            r_flg   <= 1'b0;
            r_div0  <= 1'b1;
            r_state <= S_RSP0;
          end else begin
            r_div0  <= 1'b0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_wait == WW'(ALU_LATENCY - 1)) begin
            r_res   <= i_alu_out;
            r_flg   <= i_alu_flag;
            r_state <= S_RSP0;
          end else begin
            r_wait <= r_wait + WW'(1);
          end
        end
        S_RSP0: if (i_rsp_ready) r_state <= S_RSP1;
        S_RSP1: if (i_rsp_ready) r_state <= S_OP;
        default: r_state <= S_OP;
      endcase
    end
  end

  always_comb begin
    w_status            = '0;
    w_status[STAT_FLAG] = r_flg;
    w_status[STAT_DIV0] = r_div0;
  end

  always_comb begin
    o_rsp_data = '0;
    if (r_state == S_RSP0)      o_rsp_data = r_res;
    else if (r_state == S_RSP1) o_rsp_data = w_status;
  end

  assign o_cmd_ready = !rst && ((r_state == S_OP) || (r_state == S_A) || (r_state == S_B));
  assign o_rsp_valid = (r_state == S_RSP0) || (r_state == S_RSP1);
  assign o_busy      = (r_state != S_OP);
  assign o_alu_a     = r_alu_a;
  assign o_alu_b     = r_alu_b;
  assign o_alu_sel   = r_alu_sel;
  assign o_alu_load  = r_alu_load;
  assign o_frame_err = r_frame_err;

endmodule
